mem_access_unit: RTL and testbench

- MEM-stage data-memory engine.
- Consumes the memory fields of the decoded control word: mem_read, mem_write, funct3, and the byte-enable intent. Also takes the ALU address and rs2 data.
- Drives a single-outstanding request/response data-cache port, stalling the pipeline until the response arrives.
- Aligns store data and byte enables. Extracts and sign/zero-extends load data for writeback.

---
 rtl/rv32i_types.sv | 66 ++++++
 rtl/mem_load_align.sv | 33 +++
 rtl/mem_access_unit.sv | 136 +++++++++++++
 tb/tb_mem_access_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
`default_nettype none
// ============================================================================
//  Module   : rv32i_types (package)
//  Purpose  : Shared types and access-alignment helpers for the MEM stage.
//  Revision : 1.0 - initial release
// ============================================================================
package rv32i_types;

    localparam int c_WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mau_state_t;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        F3_SB = 3'b000,
        F3_SH = 3'b001,
        F3_SW = 3'b010
    } store_funct3_t;

    // Lane mask for a store; unknown sizes fall back to a full word.
    function automatic logic [c_WORD_BYTES-1:0] store_be(input logic [2:0] f3,
                                                         input logic [1:0] off);
        case (f3)
            F3_SB:   return 4'b0001 << off;
            F3_SH:   return 4'b0011 << {off[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0]  f3,
                                                input logic [31:0] d);
        case (f3)
            F3_SB:   return {4{d[7:0]}};
            F3_SH:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic access_misaligned(input logic       is_load,
                                               input logic [2:0] f3,
                                               input logic [1:0] off);
        logic r;
        r = 1'b0;
        if (is_load) begin
            if ((f3 == F3_LH) || (f3 == F3_LHU)) r = off[0];
            else if (f3 == F3_LW)                r = (off != 2'b00);
        end else begin
            if (f3 == F3_SH)      r = off[0];
            else if (f3 == F3_SW) r = (off != 2'b00);
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_load_align.sv
`default_nettype none
// ============================================================================
//  Module   : mem_load_align
//  Purpose  : Selects the addressed lane of a read word and extends it.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_load_align
    import rv32i_types::*;
(
    input  logic [31:0] rdata_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    output logic [31:0] data_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = rdata_i[{off_i, 3'b000} +: 8];
        // Halfword lane ignores off[0] so unaligned halves read the enclosing half.
        w_half = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (funct3_i)
            F3_LB:   data_o = {{24{w_byte[7]}}, w_byte};
            F3_LH:   data_o = {{16{w_half[15]}}, w_half};
            F3_LBU:  data_o = {24'h000000, w_byte};
            F3_LHU:  data_o = {16'h0000, w_half};
            default: data_o = rdata_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_unit
//  Purpose  : MEM-stage load/store engine driving a single-outstanding dcache
//             port. Define MEM_MISALIGN_TRAP_EN to flag misaligned accesses.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import rv32i_types::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_i,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [2:0]          funct3,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   store_data_i,
    output logic                stall_o,
    output logic                done_o,
    output logic [DATA_W-1:0]   load_data_o,
    output logic                misaligned_o,
    output logic                dmem_read,
    output logic                dmem_write,
    output logic [ADDR_W-1:0]   dmem_address,
    output logic [DATA_W-1:0]   dmem_wdata,
    output logic [3:0]          dmem_byte_enable,
    input  logic                dmem_resp,
    input  logic [DATA_W-1:0]   dmem_rdata
);

    mau_state_t          state_q;
    logic                is_load_q;
    logic [2:0]          funct3_q;
    logic [1:0]          off_q;
    logic                dmem_read_q;
    logic                dmem_write_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [3:0]          be_q;
    logic [DATA_W-1:0]   load_data_q;
    logic                done_q;
    logic                mis_q;

    logic                w_accept;
    logic                w_is_load;
    logic [1:0]          w_off;
    logic                w_mis;
    logic [DATA_W-1:0]   w_load_ext;

    assign w_accept  = (state_q == IDLE) && valid_i && (mem_read || mem_write);
    assign w_is_load = mem_read;
    assign w_off     = addr_i[1:0];

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_mis = access_misaligned(w_is_load, funct3, w_off);
`else
    assign w_mis = 1'b0;
`endif

    mem_load_align u_load_align (
        .rdata_i  (dmem_rdata),
        .funct3_i (funct3_q),
        .off_i    (off_q),
        .data_o   (w_load_ext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            is_load_q    <= 1'b0;
            funct3_q     <= 3'b000;
            off_q        <= 2'b00;
            dmem_read_q  <= 1'b0;
            dmem_write_q <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= 4'b0000;
            load_data_q  <= '0;
            done_q       <= 1'b0;
            mis_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            mis_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (w_accept) begin
                        is_load_q <= w_is_load;
                        funct3_q  <= funct3;
                        off_q     <= w_off;
                        addr_q    <= {addr_i[ADDR_W-1:2], 2'b00};
                        wdata_q   <= store_wdata(funct3, store_data_i);
                        be_q      <= w_is_load ? 4'b1111 : store_be(funct3, w_off);
                        if (w_mis) begin
                            // Trapped access: skip the cache and report directly.
                            state_q     <= DONE;
                            done_q      <= 1'b1;
                            mis_q       <= 1'b1;
                            load_data_q <= '0;
                        end else begin
                            state_q      <= BUSY;
                            dmem_read_q  <= w_is_load;
                            dmem_write_q <= ~w_is_load;
                        end
                    end
                end
                BUSY: begin
                    if (dmem_resp) begin
                        dmem_read_q  <= 1'b0;
                        dmem_write_q <= 1'b0;
                        done_q       <= 1'b1;
                        state_q      <= DONE;
                        if (is_load_q) load_data_q <= w_load_ext;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall_o          = w_accept || (state_q == BUSY);
    assign done_o           = done_q;
    assign misaligned_o     = mis_q;
    assign load_data_o      = load_data_q;
    assign dmem_read        = dmem_read_q;
    assign dmem_write       = dmem_write_q;
    assign dmem_address     = addr_q;
    assign dmem_wdata       = wdata_q;
    assign dmem_byte_enable = be_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_unit
//  Purpose  : Directed self-checking bench for mem_access_unit.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr_i;
    logic [31:0] store_data_i;
    logic        stall_o;
    logic        done_o;
    logic [31:0] load_data_o;
    logic        misaligned_o;
    logic        dmem_read;
    logic        dmem_write;
    logic [31:0] dmem_address;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_byte_enable;
    logic        dmem_resp;
    logic [31:0] dmem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    int          r_stall, r_done, r_req, r_done_cyc;
    logic        r_rd, r_wr, r_mis;
    logic [31:0] r_addr, r_wdata, r_data;
    logic [3:0]  r_be;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .valid_i          (valid_i),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .funct3           (funct3),
        .addr_i           (addr_i),
        .store_data_i     (store_data_i),
        .stall_o          (stall_o),
        .done_o           (done_o),
        .load_data_o      (load_data_o),
        .misaligned_o     (misaligned_o),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_address     (dmem_address),
        .dmem_wdata       (dmem_wdata),
        .dmem_byte_enable (dmem_byte_enable),
        .dmem_resp        (dmem_resp),
        .dmem_rdata       (dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one instruction, answer the request after waitn BUSY cycles, record what was seen.
    task automatic txn(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d,
                       input int waitn, input logic [31:0] rdata);
        int busy_n;
        bit finished;
        busy_n = 0; finished = 0;
        r_stall = 0; r_done = 0; r_req = 0; r_done_cyc = -1;
        r_rd = 0; r_wr = 0; r_mis = 0; r_addr = 0; r_wdata = 0; r_data = 0; r_be = 0;
        @(negedge clk);
        valid_i = 1; mem_read = rd; mem_write = wr; funct3 = f3; addr_i = a; store_data_i = d;
        #1 if (stall_o) r_stall++;
        for (int cyc = 0; cyc < 30 && !finished; cyc++) begin
            @(negedge clk);
            valid_i = 1; mem_read = 0; mem_write = 1; funct3 = 3'b111;
            addr_i = 32'hFFFF_FFFF; store_data_i = 32'h0BAD_0BAD;
            dmem_resp = 0; dmem_rdata = 32'h5A5A_5A5A;
            #1;
            if (stall_o) r_stall++;
            if (dmem_read || dmem_write) begin
                r_req++;
                r_rd = dmem_read; r_wr = dmem_write; r_addr = dmem_address;
                r_wdata = dmem_wdata; r_be = dmem_byte_enable;
                if (busy_n == waitn) begin
                    dmem_resp = 1; dmem_rdata = rdata;
                end
                busy_n++;
            end
            if (done_o) begin
                r_done++; r_done_cyc = cyc; r_data = load_data_o; r_mis = misaligned_o;
                finished = 1;
                valid_i = 0; mem_write = 0;
            end
        end
        valid_i = 0; mem_read = 0; mem_write = 0; dmem_resp = 0;
        if (!finished) check("timeout", 0, 1);
    endtask

    initial begin
        rst = 1; valid_i = 0; mem_read = 0; mem_write = 0; funct3 = 0;
        addr_i = 0; store_data_i = 0; dmem_resp = 0; dmem_rdata = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        #1;
        check("rst_stall", stall_o, 0);
        check("rst_rd", dmem_read, 0);
        check("rst_wr", dmem_write, 0);
        check("rst_addr", dmem_address, 0);
        check("rst_wdata", dmem_wdata, 0);
        check("rst_be", dmem_byte_enable, 0);
        check("rst_load", load_data_o, 0);
        check("rst_done", done_o, 0);
        check("rst_mis", misaligned_o, 0);

        // sw with two wait cycles
        txn(0, 1, 3'b010, 32'h0000_1008, 32'hDEAD_BEEF, 2, 32'h0);
        check("sw_wr", r_wr, 1);
        check("sw_rd", r_rd, 0);
        check("sw_addr", r_addr, 32'h0000_1008);
        check("sw_be", r_be, 4'hF);
        check("sw_wdata", r_wdata, 32'hDEAD_BEEF);
        check("sw_stall", r_stall, 4);
        check("sw_req_cycles", r_req, 3);
        check("sw_done_cyc", r_done_cyc, 3);
        @(negedge clk); #1;
        check("sw_done_single", done_o, 0);
        check("sw_no_load", load_data_o, 0);

        txn(0, 1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 0, 32'h0);
        check("sb_be", r_be, 4'b1000);
        check("sb_wdata", r_wdata, 32'hA5A5_A5A5);
        check("sb_addr", r_addr, 32'h0000_0100);
        check("sb_stall", r_stall, 2);
        check("sb_done_cyc", r_done_cyc, 1);

        txn(0, 1, 3'b001, 32'h0000_0102, 32'h1234_BEEF, 0, 32'h0);
        check("sh_be", r_be, 4'b1100);
        check("sh_wdata", r_wdata, 32'hBEEF_BEEF);

        txn(1, 0, 3'b000, 32'h0000_0102, 32'h0, 0, 32'h12F4_5678);
        check("lb_rd", r_rd, 1);
        check("lb_be", r_be, 4'hF);
        check("lb_addr", r_addr, 32'h0000_0100);
        check("lb_data", r_data, 32'hFFFF_FFF4);
        txn(1, 0, 3'b100, 32'h0000_0102, 32'h0, 0, 32'h12F4_5678);
        check("lbu_data", r_data, 32'h0000_00F4);
        txn(1, 0, 3'b101, 32'h0000_0102, 32'h0, 0, 32'h12F4_5678);
        check("lhu_data", r_data, 32'h0000_12F4);
        txn(1, 0, 3'b001, 32'h0000_0100, 32'h0, 1, 32'h0000_8001);
        check("lh_data", r_data, 32'hFFFF_8001);

        txn(0, 1, 3'b010, 32'h0000_0200, 32'h7777_7777, 0, 32'h0);
        check("store_keeps_load", r_data, 32'hFFFF_8001);

        txn(1, 1, 3'b010, 32'h0000_0104, 32'h1111_1111, 0, 32'hCAFE_F00D);
        check("both_rd", r_rd, 1);
        check("both_wr", r_wr, 0);
        check("both_data", r_data, 32'hCAFE_F00D);

        // back-to-back loads; second accept must land in the IDLE cycle after DONE
        txn(1, 0, 3'b010, 32'h0000_0010, 32'h0, 0, 32'h1111_1111);
        check("b2b1_req", r_req, 1);
        check("b2b1_done_cyc", r_done_cyc, 1);
        check("b2b1_data", r_data, 32'h1111_1111);
        txn(1, 0, 3'b010, 32'h0000_0014, 32'h0, 0, 32'h2222_2222);
        check("b2b2_stall", r_stall, 2);
        check("b2b2_req", r_req, 1);
        check("b2b2_done", r_done, 1);
        check("b2b2_addr", r_addr, 32'h0000_0014);
        check("b2b2_data", r_data, 32'h2222_2222);

        // reset while BUSY
        @(negedge clk);
        valid_i = 1; mem_read = 1; funct3 = 3'b010; addr_i = 32'h0000_0300;
        @(negedge clk);
        valid_i = 0; mem_read = 0;
        #1;
        check("rstb_req", dmem_read, 1);
        check("rstb_stall", stall_o, 1);
        rst = 1;
        #1;
        check("rstb_req_drop", dmem_read, 0);
        check("rstb_stall_drop", stall_o, 0);
        @(negedge clk);
        rst = 0; dmem_resp = 1; dmem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        dmem_resp = 0;
        #1;
        check("rstb_no_done", done_o, 0);
        @(negedge clk); #1;
        check("rstb_no_done2", done_o, 0);
        check("rstb_idle_stall", stall_o, 0);
        check("rstb_idle_rd", dmem_read, 0);
        check("rstb_load_clr", load_data_o, 0);

        txn(1, 0, 3'b010, 32'h0000_0106, 32'h0, 0, 32'hA5B6_C7D8);
`ifdef MEM_MISALIGN_TRAP_EN
        check("lwmis_req", r_req, 0);
        check("lwmis_done_cyc", r_done_cyc, 0);
        check("lwmis_mis", r_mis, 1);
        check("lwmis_data", r_data, 0);
        check("lwmis_stall", r_stall, 1);
        txn(0, 1, 3'b001, 32'h0000_0101, 32'h0000_1234, 0, 32'h0);
        check("shmis_req", r_req, 0);
        check("shmis_mis", r_mis, 1);
`else
        check("lwmis_addr", r_addr, 32'h0000_0104);
        check("lwmis_data", r_data, 32'hA5B6_C7D8);
        check("lwmis_mis", r_mis, 0);
        check("lwmis_done_cyc", r_done_cyc, 1);
        txn(1, 0, 3'b101, 32'h0000_0103, 32'h0, 0, 32'hBEEF_0000);
        check("lhumis_data", r_data, 32'h0000_BEEF);
`endif
        @(negedge clk); #1;
        check("end_done", done_o, 0);
        check("end_stall", stall_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
